// File: rtl/pc_fetch.sv
// Instruction fetch front-end: PC register, single-request memory handshake and instruction holding register.
// Optional misaligned-NPC trap to HALT enabled by defining PC_FETCH_MISALIGN_CHECK_EN.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        instr_ready,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [25:0] imm26,
  output logic [31:0] fetch_cnt,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] fetch_cnt_q;
  logic        cnt_en;
  logic        err_set;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    cnt_en   = 1'b0;
    err_set  = 1'b0;
    imem_req = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          cnt_en  = 1'b1;
          state_d = FETCH;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
          // A misaligned target freezes the PC at the offending instruction for debug.
          if (npc[1:0] != 2'b00) begin
            err_set = 1'b1;
            state_d = HALT;
          end else begin
            pc_d = npc;
          end
`else
          pc_d = {npc[31:2], 2'b00};
`endif
        end
      end
      HALT:    valid_d = 1'b0;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  // Counter wraps naturally at 2^32; it is only written on consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
    end else if (cnt_en) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

`ifdef PC_FETCH_MISALIGN_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign misalign_err = err_q;
`else
  logic unused_misalign;
  assign unused_misalign = err_set ^ (^npc[1:0]);
  assign misalign_err    = 1'b0;
`endif

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign imm26       = instr_q[25:0];
  assign fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: stimulus pushes expected (pc, instr) pairs, a negedge monitor checks each presented instruction.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] npc;
  logic        instr_ready = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic [25:0] imm26;
  logic [31:0] fetch_cnt;
  logic        misalign_err;

  logic        npc_follow = 1'b0;
  logic [31:0] npc_man = 32'd0;
  logic        rdata_fixed_en = 1'b0;
  logic [31:0] rdata_fixed = 32'd0;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  always_comb begin
    npc        = npc_follow ? (pc + 32'd4) : npc_man;
    imem_rdata = rdata_fixed_en ? rdata_fixed : {8'hC0, imem_addr[23:0]};
  end

  pc_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .npc          (npc),
    .instr_ready  (instr_ready),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .imm26        (imm26),
    .fetch_cnt    (fetch_cnt),
    .misalign_err (misalign_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    #1 rst = 1'b1;
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_cnt", fetch_cnt, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_err", {31'd0, misalign_err}, 32'd0);
    #1 rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] i);
    exp_t e;
    e.pc = p;
    e.instr = i;
    exp_q.push_back(e);
  endtask

  // Monitor: every rising instr_valid must match the oldest expected pair.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (instr_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL mon_unexpected: actual pc=%h instr=%h required=no instruction", pc, instr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("mon_pc", pc, e.pc);
          check("mon_instr", instr, e.instr);
          check("mon_imm26", {6'd0, imm26}, {6'd0, e.instr[25:0]});
        end
      end
      prev_v = instr_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, before any clock edge
    #1 rst = 1'b1;
    #1;
    check("init_pc", pc, 32'h0000_3000);
    check("init_addr", imem_addr, 32'h0000_3000);
    check("init_req", {31'd0, imem_req}, 32'd0);
    check("init_valid", {31'd0, instr_valid}, 32'd0);
    check("init_instr", instr, 32'd0);
    check("init_cnt", fetch_cnt, 32'd0);
    check("init_err", {31'd0, misalign_err}, 32'd0);
    tick();
    tick();

    // Back-to-back stream: one fetch per two cycles
    rst = 1'b0;
    npc_follow = 1'b1;
    imem_ack = 1'b1;
    instr_ready = 1'b1;
    push(32'h0000_3000, 32'hC000_3000);
    push(32'h0000_3004, 32'hC000_3004);
    push(32'h0000_3008, 32'hC000_3008);
    push(32'h0000_300C, 32'hC000_300C);
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e % 2 == 1) begin
        check("t1_req", {31'd0, imem_req}, 32'd1);
        check("t1_addr", imem_addr, 32'h0000_3000 + 32'(2 * (e - 1)));
        check("t1_cnt", fetch_cnt, 32'((e - 1) / 2));
      end else begin
        check("t1_req_hold", {31'd0, imem_req}, 32'd0);
      end
    end
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    check("t1_pc_3010", pc, 32'h0000_3010);

    // Async reset mid-FETCH, then delayed ack
    pulse_rst();
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t2_req_wait", {31'd0, imem_req}, 32'd1);
      check("t2_pc_wait", pc, 32'h0000_3000);
      check("t2_valid_wait", {31'd0, instr_valid}, 32'd0);
      tick();
    end
    check("t2_req_4th", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    rdata_fixed_en = 1'b1;
    rdata_fixed = 32'h2001_0005;
    push(32'h0000_3000, 32'h2001_0005);
    tick();
    check("t2_instr", instr, 32'h2001_0005);
    check("t2_valid", {31'd0, instr_valid}, 32'd1);
    check("t2_imm26", {6'd0, imm26}, 32'h0001_0005);
    check("t2_req_hold", {31'd0, imem_req}, 32'd0);

    // Stall in HOLD with toggling npc; ack is ignored here
    npc_follow = 1'b0;
    for (int i = 0; i < 5; i++) begin
      npc_man = (i % 2 == 1) ? 32'hDEAD_BEE0 : 32'h0000_1230;
      tick();
      check("t3_pc", pc, 32'h0000_3000);
      check("t3_instr", instr, 32'h2001_0005);
      check("t3_valid", {31'd0, instr_valid}, 32'd1);
      check("t3_req", {31'd0, imem_req}, 32'd0);
    end
    npc_man = 32'h0000_5000;
    instr_ready = 1'b1;
    imem_ack = 1'b0;
    tick();
    check("t3_pc_load", pc, 32'h0000_5000);
    check("t3_valid_fall", {31'd0, instr_valid}, 32'd0);
    check("t3_instr_kept", instr, 32'h2001_0005);
    check("t3_cnt", fetch_cnt, 32'd1);
    check("t3_req_fetch", {31'd0, imem_req}, 32'd1);
    instr_ready = 1'b0;

    // Misaligned next PC
    pulse_rst();
    tick();
    imem_ack = 1'b1;
    rdata_fixed = 32'h1234_5678;
    push(32'h0000_3000, 32'h1234_5678);
    tick();
    npc_man = 32'h0000_3006;
    instr_ready = 1'b1;
    tick();
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    check("t4_err", {31'd0, misalign_err}, 32'd1);
    check("t4_pc", pc, 32'h0000_3000);
    check("t4_req", {31'd0, imem_req}, 32'd0);
    check("t4_valid", {31'd0, instr_valid}, 32'd0);
    check("t4_cnt", fetch_cnt, 32'd1);
    tick();
    tick();
    check("t4_halt_pc", pc, 32'h0000_3000);
    check("t4_halt_req", {31'd0, imem_req}, 32'd0);
    check("t4_halt_err", {31'd0, misalign_err}, 32'd1);
    check("t4_halt_valid", {31'd0, instr_valid}, 32'd0);
`else
    check("t4_pc", pc, 32'h0000_3004);
    check("t4_err", {31'd0, misalign_err}, 32'd0);
    check("t4_req", {31'd0, imem_req}, 32'd1);
    check("t4_cnt", fetch_cnt, 32'd1);
`endif
    imem_ack = 1'b0;
    instr_ready = 1'b0;

    // Counter wrap
    pulse_rst();
    tick();
    imem_ack = 1'b1;
    rdata_fixed_en = 1'b0;
    push(32'h0000_3000, 32'hC000_3000);
    tick();
    imem_ack = 1'b0;
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt_q;
    tick();
    check("t5_cnt_max", fetch_cnt, 32'hFFFF_FFFF);
    npc_follow = 1'b1;
    instr_ready = 1'b1;
    tick();
    check("t5_cnt_wrap", fetch_cnt, 32'd0);
    check("t5_pc", pc, 32'h0000_3004);
    check("t5_req", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    push(32'h0000_3004, 32'hC000_3004);
    tick();
    check("t5_valid", {31'd0, instr_valid}, 32'd1);
    tick();
    check("t5_cnt_next", fetch_cnt, 32'd1);
    check("t5_pc_next", pc, 32'h0000_3008);
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, SHALL be the PC value loaded on reset.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 npc  input  32  next-PC from next-PC logic; sampled only on consume.
REQ-005 instr_ready  input  1  downstream accepts held instruction this cycle.
REQ-006 imem_ack  input  1  instruction memory returns imem_rdata this cycle.
REQ-007 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-008 pc  output  32  PC of the instruction being fetched or held.
REQ-009 imem_req  output  1  fetch request, combinational from state (FETCH only).
REQ-010 imem_addr  output  32  equals pc at all times.
REQ-011 instr  output  32  registered instruction word.
REQ-012 instr_valid  output  1  instr and pc are a valid pair.
REQ-013 imm26  output  26  equals instr[25:0] (jump target field).
REQ-014 fetch_cnt  output  32  count of consumed instructions.
REQ-015 misalign_err  output  1  sticky misaligned-NPC flag.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, HOLD, HALT; encoding free.
REQ-017 IDLE SHALL go to FETCH on the next clock edge unconditionally.
REQ-018 FETCH: imem_req=1; on edge with imem_ack=1, instr<=imem_rdata, instr_valid<=1, go HOLD; without ack, stay FETCH, all registers hold.
REQ-019 HOLD: imem_req=0; on edge with instr_ready=1 (consume), pc<=npc, instr_valid<=0, fetch_cnt<=fetch_cnt+1, go FETCH; otherwise hold everything.
REQ-020 instr SHALL retain its last value after instr_valid falls; only instr_valid qualifies it.
REQ-021 imem_ack outside FETCH and instr_ready outside HOLD SHALL be ignored.
REQ-022 Minimum throughput SHALL be one instruction per 2 cycles (ack in first FETCH cycle, ready in first HOLD cycle).
REQ-023 fetch_cnt SHALL wrap 32'hFFFF_FFFF -> 0 without side effects.
REQ-024 HALT SHALL be absorbing: imem_req=0, instr_valid=0, pc frozen, until rst.

Reset
REQ-025 rst=1 SHALL immediately, without clock: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, fetch_cnt=0, misalign_err=0, hence imem_req=0.
REQ-026 rst asserted mid-FETCH or mid-HOLD SHALL discard the pending fetch/instruction; first request after release occurs from IDLE one edge later at RESET_PC.

Configuration
REQ-027 Macro PC_FETCH_MISALIGN_CHECK_EN SHALL control alignment checking.
REQ-028 Defined: on consume with npc[1:0]!=2'b00, pc SHALL NOT update, fetch_cnt SHALL still increment, misalign_err<=1, state<=HALT.
REQ-029 Undefined: pc SHALL load {npc[31:2],2'b00} on every consume, HALT unreachable, misalign_err tied 0.

Verification
REQ-030 Reset release, imem_ack=1 constant, instr_ready=1 constant, npc=pc+4 -> imem_addr sequence 0x3000,0x3004,0x3008 at one fetch per 2 cycles, fetch_cnt=3 after third consume.
REQ-031 imem_ack delayed 3 cycles with rdata=0x2001_0005 -> imem_req high 4 cycles, pc steady 0x3000, then instr=0x2001_0005, instr_valid=1, imm26=0x001_0005.
REQ-032 instr_ready held low 5 cycles in HOLD, npc toggling -> pc, instr, instr_valid unchanged; consume then loads npc present on that edge.
REQ-033 rst pulsed asynchronously mid-FETCH at pc=0x3010 -> imem_req falls same cycle, pc=0x3000, fetch_cnt=0, refetch from 0x3000.
REQ-034 With macro: consume with npc=0x3006 -> misalign_err=1, state HALT, pc stays prior value, imem_req stays 0; without macro: pc=0x3004, no error.
REQ-035 fetch_cnt preset via 2^32-1 consumes (or forced) then one consume -> fetch_cnt=0, fetch continues normally.
